// File: rtl/snake_step_ctrl.sv
// Step-timing and direction-queue controller for a snake game.
// Produces one step pulse per step period and commits queued UART direction
// commands on step boundaries, rejecting repeats, reversals and overflow.
module snake_step_ctrl #(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [2:0] direction,
  input  logic [1:0] mode,
  input  logic       pause,
  input  logic       rst1,
  output logic       step_tick,
  output logic [2:0] cur_dir,
  output logic       game_run,
  output logic [1:0] q_count,
  output logic       cmd_drop
);

  localparam int unsigned CW = $clog2(CLK_FREQ / 2 + 1);
  localparam logic [CW-1:0] LastM0 = CW'(CLK_FREQ / 4 - 1);
  localparam logic [CW-1:0] LastM1 = CW'(CLK_FREQ / 8 - 1);
  localparam logic [CW-1:0] LastM2 = CW'(CLK_FREQ / 16 - 1);
  localparam logic [CW-1:0] LastM3 = CW'(CLK_FREQ / 2 - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;

  localparam logic [2:0] DirRight = 3'd4;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    cur_dir_q, cur_dir_d;
  logic [2:0]    fifo_q [2];
  logic [2:0]    fifo_d [2];
  logic [1:0]    qcnt_q, qcnt_d;
  logic [2:0]    prev_dir_q;
  logic [1:0]    mode_q;

  logic [CW-1:0] cnt_last;
  logic          new_cmd, mode_chg, active, pop, push_req, drop, push, full;
  logic [1:0]    post_cnt;
  logic [2:0]    ref_dir;

  function automatic logic [2:0] opposite(input logic [2:0] d);
    logic [2:0] o;
    case (d)
      3'd1:    o = 3'd2;
      3'd2:    o = 3'd1;
      3'd3:    o = 3'd4;
      3'd4:    o = 3'd3;
      default: o = 3'd0;
    endcase
    return o;
  endfunction

  // Terminal count for the selected speed.
  always_comb begin
    cnt_last = LastM0;
    unique case (mode)
      2'd0: cnt_last = LastM0;
      2'd1: cnt_last = LastM1;
      2'd2: cnt_last = LastM2;
      2'd3: cnt_last = LastM3;
      default: cnt_last = LastM0;
    endcase
  end

  // Command detection, step pulse, queue pop/push decisions.
  always_comb begin
    new_cmd   = (direction != prev_dir_q) && (direction >= 3'd1) && (direction <= 3'd4);
    mode_chg  = (mode != mode_q);
    active    = (state_q == RUN) || (state_q == PAUSE);
    step_tick = (state_q == RUN) && !pause && !mode_chg && !rst1 && (cnt_q == cnt_last);
    pop       = step_tick && (qcnt_q != 2'd0);
    // Popped head becomes the direction in the step cycle itself.
    cur_dir   = pop ? fifo_q[0] : cur_dir_q;
    post_cnt  = qcnt_q - {1'b0, pop};
    // Reference is the tail of the queue as it stands after any pop.
    if (post_cnt == 2'd0) begin
      ref_dir = cur_dir;
    end else if ((post_cnt == 2'd1) && !pop) begin
      ref_dir = fifo_q[0];
    end else begin
      ref_dir = fifo_q[1];
    end
    full     = (post_cnt == 2'd2);
    push_req = active && new_cmd && !rst1;
    drop     = push_req && (full || (direction == ref_dir) || (direction == opposite(ref_dir)));
    push     = push_req && !drop;
    cmd_drop = drop;
    game_run = (state_q == RUN);
    q_count  = qcnt_q;
  end

  // Next-state for FSM, step counter, committed direction and FIFO.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_dir_d = cur_dir;
    fifo_d    = fifo_q;
    qcnt_d    = post_cnt + {1'b0, push};
    if (pop) fifo_d[0] = fifo_q[1];
    if (push) fifo_d[post_cnt[0]] = direction;

    if (rst1) begin
      state_d   = IDLE;
      cnt_d     = '0;
      cur_dir_d = DirRight;
      qcnt_d    = 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (new_cmd) begin
            cur_dir_d = direction;
            state_d   = RUN;
            cnt_d     = '0;
          end
        end
        RUN: begin
          if (pause) state_d = PAUSE;
          if (mode_chg || step_tick) cnt_d = '0;
          else if (!pause) cnt_d = cnt_q + 1'b1;
        end
        PAUSE: begin
          if (!pause) state_d = RUN;
          if (mode_chg) cnt_d = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cur_dir_q  <= DirRight;
      fifo_q[0]  <= 3'd0;
      fifo_q[1]  <= 3'd0;
      qcnt_q     <= 2'd0;
      prev_dir_q <= 3'd0;
      mode_q     <= 2'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_dir_q  <= cur_dir_d;
      fifo_q[0]  <= fifo_d[0];
      fifo_q[1]  <= fifo_d[1];
      qcnt_q     <= qcnt_d;
      prev_dir_q <= direction;
      mode_q     <= mode;
    end
  end

endmodule

// File: tb/tb_snake_step_ctrl.sv
// Directed bench for snake_step_ctrl with CLK_FREQ = 400 (periods 100/50/25/200).
// Expected step cycles and directions are queued when the causing stimulus is driven.
module tb_snake_step_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] direction;
  logic [1:0] mode;
  logic       pause;
  logic       rst1;
  logic       step_tick;
  logic [2:0] cur_dir;
  logic       game_run;
  logic [1:0] q_count;
  logic       cmd_drop;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_cyc[$];
  logic [2:0] exp_dir[$];

  snake_step_ctrl #(.CLK_FREQ(400)) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .direction(direction),
    .mode     (mode),
    .pause    (pause),
    .rst1     (rst1),
    .step_tick(step_tick),
    .cur_dir  (cur_dir),
    .game_run (game_run),
    .q_count  (q_count),
    .cmd_drop (cmd_drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_tick(input int c, input logic [2:0] d);
    exp_cyc.push_back(c);
    exp_dir.push_back(d);
  endtask

  // Pop the next expected step and wait (bounded) for the DUT to produce it.
  task automatic wait_tick();
    int ec;
    logic [2:0] ed;
    bit seen;
    seen = 1'b0;
    ec = exp_cyc.pop_front();
    ed = exp_dir.pop_front();
    for (int i = 0; i < 1000 && !seen; i++) begin
      next();
      if (step_tick) seen = 1'b1;
    end
    check("tick_seen", 32'(seen), 1);
    if (seen) begin
      check("tick_cycle", cyc, ec);
      check("tick_dir", 32'(cur_dir), 32'(ed));
    end
  endtask

  task automatic count_ticks(input int n, output int t);
    t = 0;
    for (int i = 0; i < n; i++) begin
      next();
      if (step_tick) t++;
    end
  endtask

  initial begin
    int t;
    int p0;
    rst_n = 1'b0;
    direction = 3'd0;
    mode = 2'd0;
    pause = 1'b0;
    rst1 = 1'b0;
    #23;
    check("rst_game_run", 32'(game_run), 0);
    check("rst_cur_dir", 32'(cur_dir), 4);
    check("rst_q_count", 32'(q_count), 0);
    check("rst_step_tick", 32'(step_tick), 0);
    check("rst_cmd_drop", 32'(cmd_drop), 0);
    rst_n = 1'b1;

    // Idle with no command: nothing happens.
    count_ticks(500, t);
    check("idle_ticks", t, 0);
    check("idle_game_run", 32'(game_run), 0);
    check("idle_cur_dir", 32'(cur_dir), 4);

    // First command LEFT loads directly and starts stepping.
    direction = 3'd3;
    expect_tick(cyc + 100, 3'd3);
    expect_tick(cyc + 200, 3'd3);
    #1 check("a_idle_before", 32'(game_run), 0);
    next();
    check("a_run", 32'(game_run), 1);
    check("a_cur_dir", 32'(cur_dir), 3);
    wait_tick();
    wait_tick();

    // Soft reset back to IDLE, then start RIGHT.
    next(); rst1 = 1'b1;
    next(); rst1 = 1'b0;
    check("r1_game_run", 32'(game_run), 0);
    check("r1_cur_dir", 32'(cur_dir), 4);
    direction = 3'd4;
    expect_tick(cyc + 100, 3'd1);
    next();
    check("b_cur_dir", 32'(cur_dir), 4);
    direction = 3'd3;
    #1 check("b_reverse_drop", 32'(cmd_drop), 1);
    next();
    check("b_q_after_drop", 32'(q_count), 0);
    direction = 3'd1;
    #1 check("b_up_nodrop", 32'(cmd_drop), 0);
    next();
    check("b_q_after_up", 32'(q_count), 1);
    wait_tick();
    next();
    check("b_q_after_pop", 32'(q_count), 0);
    check("b_dir_after_pop", 32'(cur_dir), 1);

    // Fill the queue, overflow, then push in the same cycle as a pop.
    next(); rst1 = 1'b1;
    next(); rst1 = 1'b0;
    direction = 3'd4;
    expect_tick(cyc + 100, 3'd1);
    expect_tick(cyc + 200, 3'd3);
    expect_tick(cyc + 300, 3'd1);
    next(); direction = 3'd1;
    #1 check("c_push1_nodrop", 32'(cmd_drop), 0);
    next(); direction = 3'd3;
    #1 check("c_push2_nodrop", 32'(cmd_drop), 0);
    next(); direction = 3'd2;
    #1 check("c_full_drop", 32'(cmd_drop), 1);
    next();
    check("c_q_full", 32'(q_count), 2);
    wait_tick();
    direction = 3'd1;
    #1 check("c_poppush_nodrop", 32'(cmd_drop), 0);
    next();
    check("c_q_poppush", 32'(q_count), 2);
    wait_tick();
    wait_tick();

    // Pause at counter 40 for 300 cycles.
    for (int i = 0; i < 41; i++) next();
    pause = 1'b1;
    p0 = cyc;
    next();
    check("d_paused", 32'(game_run), 0);
    count_ticks(299, t);
    check("d_pause_ticks", t, 0);
    check("d_pause_cycle", cyc, p0 + 300);
    pause = 1'b0;
    expect_tick(p0 + 360, 3'd1);
    wait_tick();

    // Speed change mid-count restarts the period.
    for (int i = 0; i < 31; i++) next();
    mode = 2'd2;
    expect_tick(cyc + 25, 3'd1);
    expect_tick(cyc + 50, 3'd1);
    wait_tick();
    wait_tick();

    // Invalid direction ignored; then fill queue and soft reset.
    next(); direction = 3'd6;
    #1 check("e_invalid_nodrop", 32'(cmd_drop), 0);
    next();
    check("e_q_invalid", 32'(q_count), 0);
    direction = 3'd3;
    next(); direction = 3'd2;
    next();
    check("e_q_two", 32'(q_count), 2);
    rst1 = 1'b1;
    next(); rst1 = 1'b0;
    check("e_r1_game_run", 32'(game_run), 0);
    check("e_r1_q", 32'(q_count), 0);
    check("e_r1_cur_dir", 32'(cur_dir), 4);
    count_ticks(300, t);
    check("e_r1_ticks", t, 0);

    // Asynchronous reset in mid-period.
    direction = 3'd3;
    for (int i = 0; i < 10; i++) next();
    check("f_running", 32'(game_run), 1);
    #2 rst_n = 1'b0;
    #1;
    check("f_arst_game_run", 32'(game_run), 0);
    check("f_arst_cur_dir", 32'(cur_dir), 4);
    check("f_arst_q", 32'(q_count), 0);
    check("f_arst_tick", 32'(step_tick), 0);
    direction = 3'd0;
    next(); next();
    rst_n = 1'b1;
    count_ticks(200, t);
    check("f_post_ticks", t, 0);
    check("f_post_idle", 32'(game_run), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/snake_step_ctrl.md
SNAKE_STEP_CTRL -- requirements
Module: snake_step_ctrl

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 sys_clk  input  1  system clock; all state changes on rising edge.
REQ-003 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 direction  input  3  level command from UART receiver: 0 none, 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT, 5-7 invalid.
REQ-005 mode  input  2  speed select: 0 = 4 steps/s, 1 = 8, 2 = 16, 3 = 2.
REQ-006 pause  input  1  level; high freezes stepping.
REQ-007 rst1  input  1  soft reset, active-high, sampled synchronously.
REQ-008 step_tick  output  1  one-cycle pulse per game step.
REQ-009 cur_dir  output  3  committed movement direction, same encoding as direction.
REQ-010 game_run  output  1  high in state RUN.
REQ-011 q_count  output  2  pending-command count, 0..2.
REQ-012 cmd_drop  output  1  one-cycle pulse when a command is discarded.

Function
REQ-013 Step period P = CLK_FREQ/4, /8, /16, /2 cycles for mode 0,1,2,3; integer division, truncated.
REQ-014 States IDLE, RUN, PAUSE; encoding free.
REQ-015 New command = cycle where direction differs from its previous-cycle registered value and is in 1..4; a change to 0 or 5-7 is ignored without a drop pulse.
REQ-016 IDLE: first new command loads cur_dir directly (no reversal check), queue unchanged, -> RUN next cycle, counter = 0.
REQ-017 RUN: counter increments each cycle; at P-1 step_tick high for that cycle, counter -> 0.
REQ-018 RUN with pause high -> PAUSE; PAUSE with pause low -> RUN; counter holds in PAUSE, no step_tick.
REQ-019 Pause sampled high in the cycle counter = P-1 suppresses that tick; counter holds at P-1.
REQ-020 Queue: 2-entry FIFO; new commands accepted in RUN and PAUSE.
REQ-021 Reference = last queued entry, else cur_dir; command equal to reference or its 180-degree opposite (UP/DOWN, LEFT/RIGHT) is rejected with cmd_drop.
REQ-022 Command arriving with queue full and no pop in same cycle is rejected with cmd_drop.
REQ-023 On step_tick with q_count>0: head popped, cur_dir = head from the cycle step_tick is high onward.
REQ-024 Simultaneous pop and push: both occur, q_count unchanged; push checked against queue contents after pop.
REQ-025 Mode change in RUN/PAUSE restarts counter at 0 next cycle; no tick that cycle.
REQ-026 rst1 high: next edge gives state IDLE, queue empty, counter 0, cur_dir RIGHT; dominates all other events that cycle.

Reset
REQ-027 sys_rst_n low, asynchronously: state IDLE, cur_dir = 4 (RIGHT), counter 0, queue empty, q_count 0, step_tick 0, cmd_drop 0, game_run 0, previous-direction register 0.
REQ-028 After sys_rst_n deassertion, first edge behaves per Function; no tick before first command.

Verification (CLK_FREQ = 400: P = 100, 50, 25, 200)
REQ-029 Reset, direction 0 for 500 cycles -> no step_tick, game_run 0, cur_dir 4.
REQ-030 direction 3 (LEFT), mode 0 -> cur_dir 3, game_run 1; step_tick every 100 cycles, first 100 cycles after RUN entry.
REQ-031 RUN cur_dir 4; direction 3 -> cmd_drop pulse, q_count 0; direction 1 -> q_count 1; next tick cur_dir 1, q_count 0.
REQ-032 Queue two commands (1 then 3), then 2 -> cmd_drop, q_count 2; two ticks give cur_dir 1 then 3.
REQ-033 pause high at counter 40 for 300 cycles -> no tick; after release, tick 60 cycles later; mode 0->2 mid-count -> next tick 25 cycles after the change.
REQ-034 rst1 pulse with q_count 2 during RUN -> IDLE, q_count 0, cur_dir 4, ticks stop; sys_rst_n pulse mid-period -> all outputs at reset values immediately.
